openip_stream_arbiter: RTL and testbench
========================================

// Module: openip_stream_arbiter
// PURPOSE
//  Round-robin arbiter that shares one valid/ready output stream between NUM_INPUTS requesters.
//  Multi-beat packets (framed by *_last) are never interleaved: a grant is held until the last beat.
//  A forward register stage on the output breaks the valid/data path, with full throughput.
//  Sits in front of shared regslice/FIFO chains, e.g. merging several request streams onto one bus.
// PARAMETERS
//  NUM_INPUTS  4  number of requesters, >=1
//  DATA_WIDTH  32 payload width per beat
//  ID_WIDTH    (NUM_INPUTS>1 ? $clog2(NUM_INPUTS) : 1)  width of r_id (derived, not overridden)
// PORTS
//  clk      in   1                      clock, all state on rising edge
//  rstn     in   1                      asynchronous active-low reset
//  w_valid  in   NUM_INPUTS             per-requester beat valid
//  w_ready  out  NUM_INPUTS             per-requester beat accepted
//  w_data   in   NUM_INPUTS*DATA_WIDTH  flattened payloads; requester i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//  w_last   in   NUM_INPUTS             beat is the final beat of its packet
//  r_valid  out  1                      output beat valid (registered)
//  r_ready  in   1                      downstream accepts beat
//  r_data   out  DATA_WIDTH             output payload (registered)
//  r_last   out  1                      output last flag (registered)
//  r_id     out  ID_WIDTH               index of the requester that sourced the beat (registered)
// BEHAVIOUR
//  Reset: r_valid=0, r_last=0, r_id=0; r_data undefined. State=IDLE. Priority pointer ptr=NUM_INPUTS-1.
//  Output slot: one-entry register; slot_free = !r_valid || r_ready (same-cycle refill allowed).
//  Beat transfer on requester i: w_valid[i] && w_ready[i]. It loads r_data/r_last/r_id and sets r_valid next cycle.
//  r_valid clears when r_ready && no beat is loaded that cycle. Latency input->output: 1 cycle, 100% throughput.
//  FSM:
//   IDLE: winner = first i with w_valid[i], searching ptr+1, ptr+2, ... mod NUM_INPUTS.
//    w_ready[winner] = slot_free; all others 0. No winner -> all w_ready 0.
//    On transfer: ptr <= winner. !w_last -> LOCKED(cur=winner); w_last -> stay IDLE.
//   LOCKED: w_ready[cur] = slot_free; all others 0 regardless of their valid.
//    On transfer with w_last[cur] -> IDLE. ptr stays cur, so cur has lowest priority next arbitration.
//  w_ready may depend combinationally on w_valid and r_ready.
//  w_valid must not depend on w_ready. Once asserted, w_valid/w_data/w_last hold until transferred.
//  Requester dropping valid mid-packet while LOCKED: arbiter waits. No other requester is granted.
//  Back-to-back packets: an IDLE-state transfer with w_last, or a LOCKED->IDLE transition, re-arbitrates the next cycle.
//   This gives zero bubbles between packets of different requesters.
//  r_ready=0 with r_valid=1: r_data/r_last/r_id stable; all w_ready=0.
//  Reset asserted mid-packet: lock dropped, output slot emptied, ptr back to NUM_INPUTS-1.
//   The partial packet is discarded; upstream must also be reset.
//  NUM_INPUTS=1: degenerates to a forward regslice with r_id=0; locking has no observable effect.
// TESTING
//  1. Only in2 valid, 3-beat packet A,B,C (last on C), r_ready=1 -> r_data A,B,C on 3 consecutive cycles, r_id=2, r_last only with C.
//  2. in0..in3 valid with single-beat packets 10,11,12,13 held, r_ready=1 -> r_id order 0,1,2,3,0,... with no bubbles.
//  3. in0 4-beat packet, in1 single beat valid from cycle 0 -> r_id 0,0,0,0,1; w_ready[1]=0 until in0 last is accepted.
//  4. r_valid=1, r_ready=0 for 5 cycles -> r_data/r_id unchanged, w_ready=0. Raise r_ready -> next beat the following cycle.
//  5. Assert rstn=0 after beat 2 of an in1 4-beat packet -> r_valid=0 immediately. With in0,in1 valid, first grant goes to in0.
//  6. Random valid/last/r_ready traffic, 10k cycles -> scoreboard per-requester order, no packet interleave, round-robin fairness.

Source files
------------

// File: rtl/openip_stream_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS valid/ready streams onto one registered output.
// Multi-beat packets (framed by w_last) keep their grant until the last beat is accepted.
module openip_stream_arbiter #(
    parameter  int NUM_INPUTS = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_INPUTS-1:0]            w_valid,
    output logic [NUM_INPUTS-1:0]            w_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] w_data,
    input  logic [NUM_INPUTS-1:0]            w_last,
    output logic                             r_valid,
    input  logic                             r_ready,
    output logic [DATA_WIDTH-1:0]            r_data,
    output logic                             r_last,
    output logic [ID_WIDTH-1:0]              r_id
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   cur_q, cur_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_last_q, r_last_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;

    logic [NUM_INPUTS-1:0] hi_mask;
    logic [NUM_INPUTS-1:0] req_hi;
    logic [ID_WIDTH-1:0]   win_hi;
    logic [ID_WIDTH-1:0]   win_any;
    logic [ID_WIDTH-1:0]   winner;
    logic                  found;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_en;
    logic                  slot_free;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic                  xfer;

    assign slot_free = !r_valid_q || r_ready;

    // Requesters above the pointer outrank those at or below it, which yields
    // the circular search order ptr+1, ptr+2, ... wrapping back to ptr itself.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_mask
        assign hi_mask[gi] = (ID_WIDTH'(gi) > ptr_q);
    end

    assign req_hi = w_valid & hi_mask;

    always_comb begin
        win_hi  = '0;
        win_any = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                win_hi = ID_WIDTH'(i);
            end
            if (w_valid[i]) begin
                win_any = ID_WIDTH'(i);
            end
        end
    end

    assign found     = |w_valid;
    assign winner    = (|req_hi) ? win_hi : win_any;
    assign grant_idx = (state_q == ST_LOCKED) ? cur_q : winner;
    assign grant_en  = (state_q == ST_LOCKED) || found;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
        assign w_ready[gi] = grant_en && slot_free && (grant_idx == ID_WIDTH'(gi));
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                sel_data = w_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last = w_last[i];
            end
        end
    end

    assign xfer = |(w_valid & w_ready);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        ptr_d     = ptr_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_last_d  = r_last_q;
        r_id_d    = r_id_q;

        // A beat loaded this cycle refills the slot even while the old one drains.
        if (xfer) begin
            r_valid_d = 1'b1;
            r_data_d  = sel_data;
            r_last_d  = sel_last;
            r_id_d    = grant_idx;
        end else if (r_ready) begin
            r_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    ptr_d = grant_idx;
                    if (!sel_last) begin
                        state_d = ST_LOCKED;
                        cur_d   = grant_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            ptr_q     <= ID_WIDTH'(NUM_INPUTS - 1);
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_last_q  <= 1'b0;
            r_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            ptr_q     <= ptr_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_last_q  <= r_last_d;
            r_id_q    <= r_id_d;
        end
    end

    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign r_last  = r_last_q;
    assign r_id    = r_id_q;

endmodule

// File: tb/tb_openip_stream_arbiter.sv
// Bench for openip_stream_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference of the arbitration rules.
module tb_openip_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    w_valid = '0;
    logic [N-1:0]    w_ready;
    logic [N*DW-1:0] w_data = '0;
    logic [N-1:0]    w_last = '0;
    logic            r_valid;
    logic            r_ready = 1'b0;
    logic [DW-1:0]   r_data;
    logic            r_last;
    logic [IW-1:0]   r_id;

    always #5 clk = ~clk;

    openip_stream_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .w_last  (w_last),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data),
        .r_last  (r_last),
        .r_id    (r_id)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Pending source beats {last, data} and beats accepted but not yet seen downstream.
    logic [DW:0] src_q[N][$];
    logic [DW:0] exp_q[N][$];
    int          seq[N];
    bit          auto_fill = 0;
    int          valid_pct = 100;
    int          rr_pct    = 100;

    // Reference state: packet ownership, last winner, and contents of the output slot.
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    bit          m_rv;
    bit          m_rl;
    logic [DW-1:0] m_rd;
    int          m_rid;
    bit          in_pkt;
    int          pkt_id;

    logic [DW-1:0] acc_data[$];
    int            acc_id[$];
    bit            acc_last[$];
    int            acc_cyc[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic gen_packet(input int i);
        int len;
        len = int'($urandom_range(4, 1));
        for (int b = 0; b < len; b++) begin
            logic [DW-1:0] d;
            d = {i[3:0], seq[i][27:0]};
            seq[i]++;
            src_q[i].push_back({(b == len - 1), d});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (auto_fill && src_q[i].size() < 2) gen_packet(i);
            if (!w_valid[i] && src_q[i].size() > 0 && int'($urandom_range(99)) < valid_pct)
                w_valid[i] = 1'b1;
            if (w_valid[i]) begin
                w_data[i*DW +: DW] = src_q[i][0][DW-1:0];
                w_last[i]          = src_q[i][0][DW];
            end
        end
        r_ready = (int'($urandom_range(99)) < rr_pct);
    endtask

    task automatic score_out();
        int id;
        logic [DW:0] e;
        id = int'(r_id);
        if (in_pkt) check("no_interleave", 64'(r_id), 64'(pkt_id));
        check("sb_nonempty", 64'(exp_q[id].size() > 0), 64'd1);
        if (exp_q[id].size() > 0) begin
            e = exp_q[id].pop_front();
            check("sb_order", {r_last, r_data}, e);
        end
        acc_data.push_back(r_data);
        acc_id.push_back(id);
        acc_last.push_back(r_last);
        acc_cyc.push_back(cyc);
        in_pkt = !r_last;
        pkt_id = id;
    endtask

    task automatic cycle();
        int          g;
        bit [N-1:0]  er;
        bit          xfer;
        bit          rr;
        logic [DW:0] hd;
        drive();
        @(negedge clk);
        cyc++;
        g = -1;
        if (m_locked) begin
            g = m_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && w_valid[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0 && (!m_rv || r_ready)) er[g] = 1'b1;
        check("w_ready", 64'(w_ready), 64'(er));
        check("r_valid", 64'(r_valid), 64'(m_rv));
        if (m_rv) begin
            check("r_data", 64'(r_data), 64'(m_rd));
            check("r_last", 64'(r_last), 64'(m_rl));
            check("r_id", 64'(r_id), 64'(m_rid));
        end
        if (r_valid && r_ready) score_out();
        xfer = (g >= 0) && er[g] && w_valid[g];
        hd   = xfer ? src_q[g][0] : '0;
        rr   = r_ready;
        @(posedge clk);
        if (xfer) begin
            m_rv  = 1'b1;
            m_rd  = hd[DW-1:0];
            m_rl  = hd[DW];
            m_rid = g;
            m_ptr = g;
            exp_q[g].push_back(hd);
            if (m_locked) begin
                if (hd[DW]) m_locked = 1'b0;
            end else if (!hd[DW]) begin
                m_locked = 1'b1;
                m_owner  = g;
            end
        end else if (rr) begin
            m_rv = 1'b0;
        end
        #1;
        if (xfer) begin
            void'(src_q[g].pop_front());
            w_valid[g] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rstn    = 1'b0;
        w_valid = '0;
        w_last  = '0;
        w_data  = '0;
        r_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        m_locked = 0; m_owner = 0; m_ptr = N - 1;
        m_rv = 0; m_rl = 0; m_rd = '0; m_rid = 0;
        in_pkt = 0; pkt_id = 0;
        acc_data.delete(); acc_id.delete(); acc_last.delete(); acc_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_r_valid", 64'(r_valid), 64'd0);
        check("reset_r_last", 64'(r_last), 64'd0);
        check("reset_r_id", 64'(r_id), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input string nm, input int n, input int budget);
        int b;
        b = 0;
        while (acc_id.size() < n && b < budget) begin
            cycle();
            b++;
        end
        check(nm, 64'(acc_id.size()), 64'(n));
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        apply_reset();

        // 1: single requester, 3-beat packet, back-to-back output
        valid_pct = 100; rr_pct = 100;
        src_q[2].push_back({1'b0, 32'h0000_000A});
        src_q[2].push_back({1'b0, 32'h0000_000B});
        src_q[2].push_back({1'b1, 32'h0000_000C});
        run_until("t1_beats", 3, 20);
        if (acc_id.size() >= 3) begin
            check("t1_d0", 64'(acc_data[0]), 64'h0A);
            check("t1_d1", 64'(acc_data[1]), 64'h0B);
            check("t1_d2", 64'(acc_data[2]), 64'h0C);
            check("t1_id", 64'(acc_id[0] + acc_id[1] + acc_id[2]), 64'd6);
            check("t1_last", 64'({acc_last[0], acc_last[1], acc_last[2]}), 64'b001);
            check("t1_consec", 64'(acc_cyc[2] - acc_cyc[0]), 64'd2);
        end

        // 2: four single-beat requesters, strict rotation with no bubbles
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) src_q[i].push_back({1'b1, 32'(16 + i)});
        run_until("t2_beats", 8, 30);
        if (acc_id.size() >= 8) begin
            for (int k = 0; k < 8; k++) check("t2_id", 64'(acc_id[k]), 64'(k % 4));
            check("t2_data4", 64'(acc_data[4]), 64'h10);
            check("t2_consec", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
        end

        // 3: locked 4-beat packet on in0 blocks in1
        apply_reset();
        for (int b = 0; b < 4; b++) src_q[0].push_back({(b == 3), 32'(32'h30 + b)});
        src_q[1].push_back({1'b1, 32'h0000_0031});
        run_until("t3_beats", 5, 30);
        if (acc_id.size() >= 5) begin
            check("t3_ids", 64'({acc_id[0][1:0], acc_id[1][1:0], acc_id[2][1:0],
                                 acc_id[3][1:0], acc_id[4][1:0]}), 64'b00_00_00_00_01);
            check("t3_in1_data", 64'(acc_data[4]), 64'h31);
        end

        // 4: output stall holds data and blocks all inputs
        apply_reset();
        rr_pct = 0;
        src_q[1].push_back({1'b0, 32'h0000_0040});
        src_q[1].push_back({1'b1, 32'h0000_0041});
        cycle();
        for (int s = 0; s < 5; s++) begin
            cycle();
            check("t4_hold_valid", 64'(r_valid), 64'd1);
            check("t4_hold_data", 64'(r_data), 64'h40);
            check("t4_hold_id", 64'(r_id), 64'd1);
            check("t4_no_ready", 64'(w_ready), 64'd0);
        end
        rr_pct = 100;
        run_until("t4_beats", 2, 20);
        if (acc_id.size() >= 2) begin
            check("t4_d1", 64'(acc_data[1]), 64'h41);
            check("t4_next", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
        end

        // 5: reset mid-packet empties the slot and restores the pointer
        apply_reset();
        for (int b = 0; b < 4; b++) src_q[1].push_back({(b == 3), 32'(32'h50 + b)});
        run_until("t5_pre", 2, 20);
        rstn = 1'b0;
        #1;
        check("t5_async_valid", 64'(r_valid), 64'd0);
        apply_reset();
        src_q[0].push_back({1'b1, 32'h0000_0060});
        src_q[1].push_back({1'b1, 32'h0000_0061});
        run_until("t5_post", 2, 20);
        if (acc_id.size() >= 2) begin
            check("t5_first_id", 64'(acc_id[0]), 64'd0);
            check("t5_first_data", 64'(acc_data[0]), 64'h60);
        end

        // 6: randomized traffic across several load profiles
        apply_reset();
        auto_fill = 1;
        for (int seg = 0; seg < 5; seg++) begin
            valid_pct = 30 + 15 * seg;
            rr_pct    = 100 - 15 * seg;
            repeat (2000) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
